// File: rtl/arbiter_writer_pkg.sv
// Shared definitions for the arbitrated bus writer: FSM encoding and default sizing.
package arbiter_writer_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/arbiter_writer_fifo.sv
// Circular byte buffer feeding the bus writer; head reads as zero when empty.
module writer_fifo import arbiter_writer_pkg::*; #(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  byte_t                    i_push_data,
  input  logic                     i_pop,
  output byte_t                    o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  byte_t              mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push_ok, pop_ok;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_head  = o_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/arbiter_writer.sv
// Buffered writer on an arbitrated shared bus: requests while bytes are queued,
// drives the bus on grant, and idles one cycle between bursts that drain the buffer.
//
// state | meaning
// IDLE  | no request, waiting for buffered bytes
// REQ   | o_req high, head held on o_data until busy drops
// GAP   | one-cycle release after the buffer drained
module arbiter_writer import arbiter_writer_pkg::*; #(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  output logic                     o_req,
  input  logic                     i_busy,
  output logic [7:0]               o_data,
  output logic                     o_data_oe,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_sent
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              grant, push, remain;
  logic              fifo_full, fifo_empty;

  assign o_req      = (state_q == ST_REQ);
  assign grant      = o_req & ~i_busy;
  assign o_data_oe  = grant;
  assign o_wr_ready = ~fifo_full;
  assign push       = i_wr_valid & o_wr_ready;

  // Bytes left after this grant: two or more queued, or one refilled this cycle.
  assign remain = (|o_count[PTR_W:1]) | push;

  writer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push),
    .i_push_data (i_wr_data),
    .i_pop       (grant),
    .o_head      (o_data),
    .o_count     (o_count),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    if (grant) sent_d = sent_q + 1'b1;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ:  if (grant) state_d = remain ? ST_REQ : ST_GAP;
      ST_GAP:  state_d = fifo_empty ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
    end
  end

  assign o_sent = sent_q;

endmodule

// File: tb/tb_arbiter_writer.sv
// Self-checking bench for arbiter_writer: reference model of buffer and FSM,
// scoreboard of expected bus bytes popped on every grant.
module tb_arbiter_writer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_GAP  = 2;

  logic              i_clk;
  logic              i_reset;
  logic [7:0]        i_wr_data;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic              o_req;
  logic              i_busy;
  logic [7:0]        o_data;
  logic              o_data_oe;
  logic [2:0]        o_count;
  logic [CNT_W-1:0]  o_sent;

  arbiter_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_data  (i_wr_data),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .o_req      (o_req),
    .i_busy     (i_busy),
    .o_data     (o_data),
    .o_data_oe  (o_data_oe),
    .o_count    (o_count),
    .o_sent     (o_sent)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb [$];
  int mcount = 0;
  int msent  = 0;
  int mst    = M_IDLE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    mcount = 0;
    msent  = 0;
    mst    = M_IDLE;
  endtask

  // Called just after a rising edge: drive inputs, check, advance model, wait one cycle.
  task automatic step(input bit push, input logic [7:0] d, input bit drop);
    bit grant, acc;
    int old_cnt;
    logic [7:0] exp_head;
    i_wr_valid = push;
    i_wr_data  = d;
    i_busy     = ~drop;
    #1;
    grant    = (mst == M_REQ) && drop;
    exp_head = (sb.size() != 0) ? sb[0] : 8'h00;
    chk("o_req",      o_req,      mst == M_REQ);
    chk("o_data_oe",  o_data_oe,  grant);
    chk("o_count",    o_count,    mcount);
    chk("o_wr_ready", o_wr_ready, mcount < DEPTH);
    chk("o_sent",     o_sent,     msent);
    chk("head",       o_data,     exp_head);
    if (o_data_oe) begin
      if (sb.size() == 0) chk("bus_underflow", o_data_oe, 0);
      else begin
        chk("bus", o_data, sb[0]);
        void'(sb.pop_front());
      end
    end else if (grant) begin
      void'(sb.pop_front());
    end
    acc     = push && (mcount < DEPTH);
    old_cnt = mcount;
    if (acc) sb.push_back(d);
    mcount = mcount + int'(acc) - int'(grant);
    msent  = (msent + int'(grant)) % (1 << CNT_W);
    case (mst)
      M_IDLE:  if (old_cnt != 0) mst = M_REQ;
      M_REQ:   if (grant) mst = (mcount != 0) ? M_REQ : M_GAP;
      default: mst = (old_cnt != 0) ? M_REQ : M_IDLE;
    endcase
    @(posedge i_clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   o_req,      0);
    chk({tag, "_count"}, o_count,    0);
    chk({tag, "_sent"},  o_sent,     0);
    chk({tag, "_ready"}, o_wr_ready, 1);
    chk({tag, "_oe"},    o_data_oe,  0);
    chk({tag, "_data"},  o_data,     8'h00);
  endtask

  initial begin
    i_reset    = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'h00;
    i_busy     = 1'b1;
    #2 i_reset = 1'b1;
    #1 check_reset_outputs("rst");
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    model_reset();

    // Single byte held against a busy bus, then one grant.
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 21; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Busy low while idle must be ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Fill to full, overflow push dropped, grant every other cycle.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);

    // Push during a grant at count 2 keeps the count and the order.
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h12, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Reset mid-request with three bytes buffered; grant attempted during reset.
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h23, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_req", o_req, 1);
    i_wr_valid = 1'b0;
    i_busy     = 1'b0;
    i_reset    = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(posedge i_clk); #1;
    chk("rst_hold_sent",  o_sent,  0);
    chk("rst_hold_count", o_count, 0);
    i_reset = 1'b0;
    i_busy  = 1'b1;
    model_reset();

    // Normal operation after reset.
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
